proc_io_port: RTL and testbench

- Peripheral-side responder for the processor I/O port. It answers req_in/addr_in reads with io_in data, and captures out_en/addr_out/io_out writes.
- Buffers an external input stream and an external output stream in two small FIFOs.
- Raises a one-cycle itr pulse when the input buffer reaches a programmable fill threshold.
- Sits between the processor instance and board-level streaming logic.

---
 rtl/proc_io_port_pkg.sv | 33 +++
 rtl/io_fifo.sv | 61 ++++++
 rtl/proc_io_port.sv | 148 ++++++++++++++
 tb/tb_proc_io_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_io_port_pkg.sv
// Shared definitions for proc_io_port: the I/O address map, the status/control
// bit layout and the sticky-flag record.
package proc_io_port_pkg;

    localparam int IO_DATA = 0;
    localparam int IO_STAT = 1;

    localparam int STAT_IN_CNT_LSB = 0;

    // Status and control bit positions are anchored to the word MSB so they
    // follow NUBITS.
    function automatic int stat_unf_bit(input int nubits);
        return nubits - 1;
    endfunction

    function automatic int stat_ovf_bit(input int nubits);
        return nubits - 2;
    endfunction

    function automatic int stat_out_cnt_lsb(input int cw);
        return cw;
    endfunction

    function automatic int ctrl_clr_bit(input int nubits);
        return nubits - 1;
    endfunction

    typedef struct packed {
        logic unf;
        logic ovf;
    } sticky_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO. It reports its head word, its fill count, and full/empty flags.
// A pop is ignored when the FIFO is empty. A push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module io_fifo #(
    parameter int NBDATA = 16,
    parameter int DEPTH  = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [NBDATA-1:0] wdata,
    input  logic              pop,
    output logic [NBDATA-1:0] head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [NBDATA-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; head is forced to zero
    // while empty, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/proc_io_port.sv
// Processor I/O port responder. It buffers an input stream and an output stream,
// exposes them and a status word to the processor, and raises an interrupt when
// the input buffer reaches its fill threshold.
module proc_io_port
    import proc_io_port_pkg::*;
#(
    parameter int NUBITS = 16,
    parameter int FDEPTH = 8,
    parameter int NUIOIN = 2,
    parameter int NUIOOU = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [NUBITS-1:0]         io_in,
    input  logic [$clog2(NUIOIN)-1:0] addr_in,
    input  logic                      req_in,
    input  logic [NUBITS-1:0]         io_out,
    input  logic [$clog2(NUIOOU)-1:0] addr_out,
    input  logic                      out_en,
    output logic                      itr,
    input  logic [NUBITS-1:0]         s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [NUBITS-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready
);

    localparam int CW          = $clog2(FDEPTH) + 1;
    localparam int AIW         = $clog2(NUIOIN);
    localparam int AOW         = $clog2(NUIOOU);
    localparam int UNF_BIT     = stat_unf_bit(NUBITS);
    localparam int OVF_BIT     = stat_ovf_bit(NUBITS);
    localparam int OUT_CNT_LSB = stat_out_cnt_lsb(CW);
    localparam int CLR_BIT     = ctrl_clr_bit(NUBITS);

    if (NUBITS < 2 * CW + 2) begin : g_bad_nubits
        $error("proc_io_port: NUBITS too narrow for the status word");
    end
    if (FDEPTH < 2 || (FDEPTH & (FDEPTH - 1)) != 0) begin : g_bad_fdepth
        $error("proc_io_port: FDEPTH must be a power of two >= 2");
    end
    if (NUIOIN < 2 || NUIOOU < 2) begin : g_bad_naddr
        $error("proc_io_port: NUIOIN and NUIOOU must be >= 2");
    end

    logic [NUBITS-1:0] in_head;
    logic [NUBITS-1:0] out_head;
    logic [NUBITS-1:0] status;
    logic [CW-1:0]     in_count;
    logic [CW-1:0]     in_count_next;
    logic [CW-1:0]     out_count;
    logic [CW-1:0]     threshold;
    logic              in_full;
    logic              in_empty;
    logic              out_full;
    logic              out_empty;
    logic              in_push;
    logic              rd_data;
    logic              in_pop;
    logic              out_wr;
    logic              out_pop;
    logic              ctrl_wr;
    logic              ctrl_clr;
    sticky_t           sticky;
    sticky_t           sticky_set;

    assign s_ready  = ~in_full;
    assign in_push  = s_valid & s_ready;
    assign rd_data  = req_in & (addr_in == AIW'(IO_DATA));
    assign in_pop   = rd_data & ~in_empty;
    assign out_wr   = out_en & (addr_out == AOW'(IO_DATA));
    assign ctrl_wr  = out_en & (addr_out == AOW'(IO_STAT));
    assign ctrl_clr = ctrl_wr & io_out[CLR_BIT];
    assign m_valid  = ~out_empty;
    assign m_data   = out_head;
    assign out_pop  = m_valid & m_ready;

    assign sticky_set.unf = rd_data & in_empty;
    assign sticky_set.ovf = out_wr & out_full & ~out_pop;

    // The interrupt detector needs the count this edge will produce, so it can
    // compare the old and the new fill level against the threshold.
    assign in_count_next = in_count + CW'(in_push) - CW'(in_pop);

    io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_in_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (in_push),
        .wdata (s_data),
        .pop   (rd_data),
        .head  (in_head),
        .count (in_count),
        .full  (in_full),
        .empty (in_empty)
    );

    io_fifo #(.NBDATA(NUBITS), .DEPTH(FDEPTH)) u_out_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (out_wr),
        .wdata (io_out),
        .pop   (m_ready),
        .head  (out_head),
        .count (out_count),
        .full  (out_full),
        .empty (out_empty)
    );

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        status                          = '0;
        status[UNF_BIT]                 = sticky.unf;
        status[OVF_BIT]                 = sticky.ovf;
        status[OUT_CNT_LSB +: CW]       = out_count;
        status[STAT_IN_CNT_LSB +: CW]   = in_count;
    end

    always_comb begin
        io_in = '0;
        if (addr_in == AIW'(IO_DATA))
            io_in = in_head;
        else if (addr_in == AIW'(IO_STAT))
            io_in = status;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            threshold <= '0;
            sticky    <= '0;
            itr       <= 1'b0;
        end else begin
            if (ctrl_wr)
                threshold <= io_out[CW-1:0];
            if (ctrl_clr) begin
                sticky <= '0;
            end else begin
                sticky.unf <= sticky.unf | sticky_set.unf;
                sticky.ovf <= sticky.ovf | sticky_set.ovf;
            end
            // Fire only on an upward crossing; a threshold write alone never fires.
            itr <= (threshold != '0) && (in_count < threshold)
                   && (in_count_next >= threshold);
        end
    end

endmodule

// File: tb/tb_proc_io_port.sv
// Self-checking bench for proc_io_port. It runs directed scenarios and then a
// random phase, and compares the DUT against a queue-based reference model.
module tb_proc_io_port;

    localparam int NUBITS = 16;
    localparam int FDEPTH = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUBITS-1:0] io_in;
    logic [0:0]        addr_in = '0;
    logic              req_in = 1'b0;
    logic [NUBITS-1:0] io_out = '0;
    logic [0:0]        addr_out = '0;
    logic              out_en = 1'b0;
    logic              itr;
    logic [NUBITS-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [NUBITS-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;

    proc_io_port #(.NUBITS(NUBITS), .FDEPTH(FDEPTH), .NUIOIN(2), .NUIOOU(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .io_in    (io_in),
        .addr_in  (addr_in),
        .req_in   (req_in),
        .io_out   (io_out),
        .addr_out (addr_out),
        .out_en   (out_en),
        .itr      (itr),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [NUBITS-1:0] in_q[$];
    logic [NUBITS-1:0] out_q[$];
    int                thr_m = 0;
    bit                unf_m = 1'b0;
    bit                ovf_m = 1'b0;
    bit                itr_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_status();
        return {unf_m, ovf_m, 6'b0, 4'(out_q.size()), 4'(in_q.size())};
    endfunction

    // One clock cycle: drive at negedge, check combinational and registered
    // outputs against the model, then advance the model at the rising edge.
    task automatic tick(input bit sv, input logic [15:0] sd, input bit rq, input bit ai,
                        input bit oe, input bit ao, input logic [15:0] od, input bit mr);
        int                old_n;
        int                new_n;
        bit                pop_o;
        logic [15:0]       exp_io;
        logic [15:0]       tmp;
        @(negedge clk);
        s_valid = sv; s_data = sd; req_in = rq; addr_in = ai;
        out_en = oe; addr_out = ao; io_out = od; m_ready = mr;
        #1;
        if (ai == 1'b0)
            exp_io = (in_q.size() != 0) ? in_q[0] : 16'h0;
        else
            exp_io = exp_status();
        check("s_ready", 32'(s_ready), 32'(in_q.size() < FDEPTH));
        check("m_valid", 32'(m_valid), 32'(out_q.size() != 0));
        check("m_data", 32'(m_data), 32'((out_q.size() != 0) ? out_q[0] : 16'h0));
        check("io_in", 32'(io_in), 32'(exp_io));
        check("itr", 32'(itr), 32'(itr_m));
        @(posedge clk);
        old_n = in_q.size();
        pop_o = (out_q.size() != 0) && mr;
        if (rq && ai == 1'b0) begin
            if (old_n != 0) tmp = in_q.pop_front();
            else            unf_m = 1'b1;
        end
        if (sv && old_n < FDEPTH) in_q.push_back(sd);
        new_n = in_q.size();
        itr_m = (thr_m != 0) && (old_n < thr_m) && (new_n >= thr_m);
        if (pop_o) tmp = out_q.pop_front();
        if (oe && ao == 1'b0) begin
            if (out_q.size() == FDEPTH) ovf_m = 1'b1;
            else                        out_q.push_back(od);
        end
        if (oe && ao == 1'b1) begin
            thr_m = int'(od[3:0]);
            if (od[15]) begin
                unf_m = 1'b0;
                ovf_m = 1'b0;
            end
        end
    endtask

    task automatic idle();
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b0; s_data = '0; req_in = 1'b0; addr_in = 1'b1;
        out_en = 1'b0; addr_out = '0; io_out = '0; m_ready = 1'b0;
        #1;
        check("rst_s_ready", 32'(s_ready), 32'(1));
        check("rst_m_valid", 32'(m_valid), 32'(0));
        check("rst_m_data", 32'(m_data), 32'(0));
        check("rst_itr", 32'(itr), 32'(0));
        check("rst_status", 32'(io_in), 32'(0));
        in_q.delete();
        out_q.delete();
        thr_m = 0; unf_m = 1'b0; ovf_m = 1'b0; itr_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        do_reset();

        // Three stream words, then read them back through address 0
        tick(1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h0022, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("stat_cnt3", 32'(io_in), 32'h0003);
        for (int i = 0; i < 3; i++)
            tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        idle();
        #1 check("stat_cnt0", 32'(io_in), 32'h0000);

        // Empty read sets underflow, a control write clears it
        tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("empty_read_io", 32'(io_in), 32'h0000);
        idle();
        #1 check("unf_set", 32'(io_in), 32'h8000);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0);
        #1 check("unf_clr", 32'(io_in), 32'h0000);

        // Fill the input FIFO; the ninth word is held off
        for (int i = 0; i < 9; i++)
            tick(1'b1, 16'(16'h0100 + i), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("in_full_cnt", 32'(io_in), 32'h0008);
        check("in_full_rdy", 32'(s_ready), 32'(0));
        tick(1'b1, 16'h01ff, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h01ff, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("in_refill_cnt", 32'(io_in), 32'h0008);
        while (in_q.size() != 0)
            tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // Threshold 4: one pulse on the fourth push only
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 16'(16'h0200 + i), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
            #1 check("itr_thr4", 32'(itr), 32'(i == 3));
        end
        for (int i = 0; i < 5; i++)
            tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b1, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        #1 check("itr_refire", 32'(itr), 32'(1));
        idle();
        #1 check("itr_one_cycle", 32'(itr), 32'(0));
        while (in_q.size() != 0)
            tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0);

        // Output stream ordering
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h1234, 1'b0);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h5678, 1'b0);
        #1 check("m_head", 32'(m_data), 32'h1234);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        #1 check("m_second", 32'(m_data), 32'h5678);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        #1 check("m_drained", 32'(m_valid), 32'(0));

        // Output overflow, then a write into a full FIFO with a concurrent pop
        for (int i = 0; i < 9; i++)
            tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'(16'h2000 + i), 1'b0);
        #1 check("ovf_set", 32'(io_in[14]), 32'(1));
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h8000, 1'b0);
        tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2009, 1'b1);
        #1 check("ovf_pop_accept", 32'(io_in), 32'h0080);
        while (out_q.size() != 0)
            tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit          oe;
            bit          ao;
            logic [15:0] od;
            oe = ($urandom_range(0, 9) < 3);
            ao = ($urandom_range(0, 9) == 0);
            od = 16'($urandom);
            if (ao)
                od = {($urandom_range(0, 7) == 0), 11'h0, 4'($urandom_range(0, 15))};
            tick(1'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0), 1'($urandom),
                 oe, ao, od, ($urandom_range(0, 2) != 0));
            if (n == 1500) do_reset();
        end

        // Reset in the middle of buffered traffic
        for (int i = 0; i < 5; i++)
            tick(1'b1, 16'(16'h0400 + i), 1'b0, 1'b1, 1'b1, 1'b0, 16'(16'h0500 + i), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++)
            tick(1'b1, 16'(16'h0600 + i), 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
